rsa_const_unit: RTL and testbench

RSA_CONST_UNIT -- requirements
Module: rsa_const_unit

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rsa_const_unit.sv | 125 ++++++++++++
 tb/tb_rsa_const_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the Montgomery-constant unit: FSM state type and
// the iteration-count helper.
package rsa_pkg;

  // FSM state encoding for rsa_const_unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of doubling/reduction steps: R^2 with R = 2^(width+2).
  function automatic int iter_count(input int width);
    return 2 * (width + 2);
  endfunction

endpackage

// File: rtl/rsa_const_unit.sv
// Computes the Montgomery constant 2^(2*(WIDTH+2)) mod M by repeated
// doubling with conditional subtraction, one step per enabled cycle.
//
// Handshake: start is sampled only in IDLE while en=1. The result is
// presented when done pulses for one enabled cycle; valid then stays high
// (with Const and err) until the next accepted start or reset. start seen
// in CALC or DONE is dropped, not queued.
module rsa_const_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int ITERS = iter_count(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Reduction step datapath: r < m_q always holds, so 2*r fits in WIDTH+1
  // bits and a single conditional subtract brings it back below m_q.
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   t_diff;
  logic [WIDTH-1:0] r_step;

  // Doubling and conditional subtraction for the current r.
  always_comb begin
    t      = {r_q, 1'b0};
    t_diff = t - {1'b0, m_q};
    r_step = (t >= {1'b0, m_q}) ? t_diff[WIDTH-1:0] : t[WIDTH-1:0];
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    const_d = const_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = M;
          r_d     = WIDTH'(1);
          cnt_d   = '0;
          const_d = '0;
          if (!M[0] || (M == WIDTH'(1))) begin
            // No inverse-friendly modulus: report and finish at once.
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            valid_d = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d   = r_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          const_d = r_step;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers: reset wins, otherwise advance only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      r_q     <= '0;
      const_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      const_q <= const_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Const     = const_q;
  assign busy      = (state_q == ST_CALC);
  assign done      = (state_q == ST_DONE);
  assign valid     = valid_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rsa_const_unit.sv
// Self-checking bench for rsa_const_unit (WIDTH=8): directed and random
// moduli compared against an arithmetic reference of 2^20 mod M.
module tb_rsa_const_unit;

  localparam int W     = 8;
  localparam int ITERS = 2 * (W + 2);

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         start;
  logic [W-1:0] M;
  logic [W-1:0] Const;
  logic         busy;
  logic         done;
  logic         valid;
  logic         err;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  rsa_const_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .M         (M),
    .Const     (Const),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: Montgomery constant straight from its definition.
  function automatic logic [W-1:0] ref_const(input logic [W-1:0] m);
    longint p;
    p = longint'(1) << (2 * (W + 2));
    return W'(p % longint'(m));
  endfunction

  function automatic bit ref_err(input logic [W-1:0] m);
    return (m % 2 == 0) || (m == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start and follow it to done. gap_n enabled-low cycles are
  // inserted during CALC; disturb re-pulses start and moves M mid-CALC.
  // stretch holds en low for a few cycles while done is high.
  task automatic run_op(input logic [W-1:0] m, input int gap_n, input bit disturb,
                        input bit stretch);
    logic [W-1:0] exp_c;
    bit           exp_e;
    int           exp_lat;
    int           lat;
    int           gap_at;
    exp_e   = ref_err(m);
    exp_c   = exp_e ? '0 : ref_const(m);
    exp_lat = exp_e ? 1 : ITERS + 1 + gap_n;
    gap_at  = $urandom_range(3, 12);
    en = 1'b1; M = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    M = W'($urandom);
    lat = 1;
    if (!exp_e) check("busy_in_calc", 32'(busy), 32'd1);
    while (!done && lat < 200) begin
      en    = !(gap_n > 0 && lat >= gap_at && lat < gap_at + gap_n);
      start = disturb && (lat == 5 || lat == 9);
      M     = (disturb && lat >= 5) ? W'(3) : W'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    en = 1'b1; start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("const", 32'(Const), 32'(exp_c));
    check("err", 32'(err), 32'(exp_e));
    check("valid_at_done", 32'(valid), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    if (stretch) begin
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("done_stretched", 32'(done), 32'd1);
      en = 1'b1;
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("valid_held", 32'(valid), 32'd1);
    check("const_held", 32'(Const), 32'(exp_c));
  endtask

  initial begin
    int   seen_done;
    logic [W-1:0] rm;
    rst = 1'b1; en = 1'b0; start = 1'b0; M = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_const", 32'(Const), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // Basic and back-to-back operation.
    run_op(8'hC5, 0, 1'b0, 1'b0);
    check("c5_ref", 32'(ref_const(8'hC5)), 32'h8E);
    run_op(8'hFF, 0, 1'b0, 1'b0);
    run_op(8'h03, 0, 1'b0, 1'b0);

    // Illegal moduli.
    run_op(8'h80, 0, 1'b0, 1'b0);
    run_op(8'h01, 0, 1'b0, 1'b0);

    // Ignored mid-CALC start and M change.
    run_op(8'hC5, 0, 1'b1, 1'b0);

    // Clock-enable gaps and done stretching.
    run_op(8'hC5, 5, 1'b0, 1'b1);

    // Reset partway through CALC aborts without a done pulse.
    M = 8'hC5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_const", 32'(Const), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_op(8'hC5, 0, 1'b0, 1'b0);

    // Random moduli with random enable gaps.
    for (int i = 0; i < 8; i++) begin
      rm = W'($urandom);
      run_op(rm, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
